// File: rtl/seven_seg_scanner.sv
// Multiplexed hex seven-segment driver with PWM dimming, leading-zero
// suppression and a frame-synchronous double-buffered load.
module seven_seg_scanner #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BRIGHT_W   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_suppress,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_done,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  seg_dp
);

  localparam int SW   = $clog2(SCAN_DIV + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STEP = SCAN_DIV >> BRIGHT_W;

  localparam logic [SW-1:0]     SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]     FULL      = SW'(SCAN_DIV);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_OFF   = {7{ACTIVE_LOW}};

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Walk down from the top digit; stop at the first digit worth showing.
  function automatic logic [DIGITS-1:0] lz_mask(
    input logic [4*DIGITS-1:0] v,
    input logic [DIGITS-1:0]   d,
    input logic                en
  );
    logic [DIGITS-1:0] m;
    logic              live;
    m    = '0;
    live = en;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (live && v[4*i +: 4] == 4'h0 && !d[i]) m[i] = 1'b1;
      else live = 1'b0;
    end
    return m;
  endfunction

  logic [SW-1:0]         slot_q, slot_d, thresh_q, thresh_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   sh_val_q, sh_val_d, ac_val_q, ac_val_d;
  logic [DIGITS-1:0]     sh_dp_q, sh_dp_d, ac_dp_q, ac_dp_d;
  logic [DIGITS-1:0]     sh_bl_q, sh_bl_d, ac_bl_q, ac_bl_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic                  sh_lz_q, sh_lz_d;
  logic                  pend_q, pend_d;
  logic                  fd_q;
  logic [DIGITS-1:0]     an_q, an_d, on;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  slot_last, idx_last, boundary, lit;
  logic [3:0]            nib;

  always_comb begin
    slot_last = slot_q == SLOT_LAST;
    idx_last  = idx_q == IDX_LAST;
    boundary  = slot_last && idx_last;
    slot_d    = slot_last ? '0 : slot_q + 1'b1;
    idx_d     = idx_q;
    if (slot_last) idx_d = idx_last ? '0 : idx_q + 1'b1;

    thresh_d = thresh_q;
    if (boundary) thresh_d = (&brightness) ? FULL : SW'(brightness * STEP);

    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    sh_bl_d  = sh_bl_q;
    sh_lz_d  = sh_lz_q;
    ac_val_d = ac_val_q;
    ac_dp_d  = ac_dp_q;
    ac_bl_d  = ac_bl_q;
    mask_d   = mask_q;
    pend_d   = pend_q;
    if (load && boundary) begin
      ac_val_d = value;
      ac_dp_d  = dp;
      ac_bl_d  = blank;
      mask_d   = lz_mask(value, dp, lz_suppress);
      pend_d   = 1'b0;
    end else if (load) begin
      sh_val_d = value;
      sh_dp_d  = dp;
      sh_bl_d  = blank;
      sh_lz_d  = lz_suppress;
      pend_d   = 1'b1;
    end else if (boundary && pend_q) begin
      ac_val_d = sh_val_q;
      ac_dp_d  = sh_dp_q;
      ac_bl_d  = sh_bl_q;
      mask_d   = lz_mask(sh_val_q, sh_dp_q, sh_lz_q);
      pend_d   = 1'b0;
    end

    nib        = ac_val_q[{idx_q, 2'b00} +: 4];
    lit        = !ac_bl_q[idx_q] && !mask_q[idx_q] && (slot_q < thresh_q);
    on         = '0;
    on[idx_q]  = lit;
    an_d       = on ^ AN_OFF;
    seg_d      = decode(nib) ^ SEG_OFF;
    dp_d       = ac_dp_q[idx_q] ^ ACTIVE_LOW;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_q   <= '0;
      idx_q    <= '0;
      thresh_q <= '0;
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      sh_bl_q  <= '0;
      sh_lz_q  <= 1'b0;
      ac_val_q <= '0;
      ac_dp_q  <= '0;
      ac_bl_q  <= '0;
      mask_q   <= '0;
      pend_q   <= 1'b0;
      fd_q     <= 1'b0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= ACTIVE_LOW;
    end else begin
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      thresh_q <= thresh_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      sh_bl_q  <= sh_bl_d;
      sh_lz_q  <= sh_lz_d;
      ac_val_q <= ac_val_d;
      ac_dp_q  <= ac_dp_d;
      ac_bl_q  <= ac_bl_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      fd_q     <= boundary;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign pending    = pend_q;
  assign frame_done = fd_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign seg_dp     = dp_q;

endmodule
